// File: rtl/fpu_forward_unit.sv
// fpu_forward_unit: shadow pipeline of in-flight FPU writers driving RAW stall and bypass selects
module fpu_forward_unit #(
  parameter int REG_W     = 5,
  parameter int DEPTH     = 4,
  parameter int NSRC      = 2,
  parameter int ZERO_SKIP = 0,
  localparam int SELW     = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NSRC*REG_W-1:0]  rs_i,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic [REG_W-1:0]       issue_rd,
  input  logic [CW-1:0]          issue_lat,
  input  logic                   hold,
  input  logic                   flush,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   raw_stall,
  output logic                   issue_accept,
  output logic                   wb_valid,
  output logic [REG_W-1:0]       wb_rd
);
  logic [DEPTH-1:0]                 v_q, v_d;
  logic [DEPTH-1:0][REG_W-1:0]      rd_q, rd_d;
  logic [DEPTH-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [NSRC-1:0]                  pend;
  logic [CW-1:0]                    lat_c;
  logic                             new_en;

  assign raw_stall    = |pend;
  assign issue_accept = issue_valid & ~raw_stall & ~hold & ~flush;
  assign wb_valid     = v_q[DEPTH-1] & ~hold & ~flush;
  assign wb_rd        = rd_q[DEPTH-1];
  assign lat_c        = issue_lat == '0 ? CW'(1) : issue_lat > CW'(DEPTH) ? CW'(DEPTH) : issue_lat;
  assign new_en       = issue_accept & issue_wen & ~(ZERO_SKIP != 0 && issue_rd == '0);

  // Per-source lookup: scan oldest to youngest so the youngest match overwrites and wins
  always_comb begin
    fwd_hit = '0;
    fwd_sel = '0;
    pend    = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (v_q[s] && rd_q[s] == rs_i[k*REG_W +: REG_W] &&
            !(ZERO_SKIP != 0 && rs_i[k*REG_W +: REG_W] == '0)) begin
          fwd_sel[k*SELW +: SELW] = SELW'(s);
          fwd_hit[k]              = cnt_q[s] == '0;
          pend[k]                 = cnt_q[s] != '0;
        end
      end
    end
  end

  // Next state: shift on advance (flush forces the shift so it overrides hold), then flush kills all
  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (!hold || flush) begin
      v_d[0]   = new_en;
      rd_d[0]  = issue_rd;
      cnt_d[0] = lat_c - CW'(1);
      for (int s = 1; s < DEPTH; s++) begin
        v_d[s]   = v_q[s-1];
        rd_d[s]  = rd_q[s-1];
        cnt_d[s] = cnt_q[s-1] == '0 ? '0 : cnt_q[s-1] - CW'(1);
      end
    end
    if (flush) v_d = '0;
  end

  // Stage state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fpu_forward_unit.sv
// tb_fpu_forward_unit: directed table plus randomized checks against an age-based queue model
module tb_fpu_forward_unit;
  localparam int REG_W = 5, DEPTH = 4, NSRC = 2;

  logic clk = 1'b0, rstn = 1'b0;
  logic [NSRC*REG_W-1:0] rs_i = '0;
  logic issue_valid = 1'b0, issue_wen = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [REG_W-1:0] issue_rd = '0;
  logic [2:0] issue_lat = '0;
  logic [1:0] hit [2];
  logic [3:0] sel [2];
  logic stall [2], acc [2], wbv [2];
  logic [4:0] wbr [2];

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fpu_forward_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .NSRC(NSRC), .ZERO_SKIP(0)) dut0 (
    .clk(clk), .rstn(rstn), .rs_i(rs_i), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .hold(hold), .flush(flush),
    .fwd_hit(hit[0]), .fwd_sel(sel[0]), .raw_stall(stall[0]), .issue_accept(acc[0]),
    .wb_valid(wbv[0]), .wb_rd(wbr[0]));

  fpu_forward_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .NSRC(NSRC), .ZERO_SKIP(1)) dut1 (
    .clk(clk), .rstn(rstn), .rs_i(rs_i), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .hold(hold), .flush(flush),
    .fwd_hit(hit[1]), .fwd_sel(sel[1]), .raw_stall(stall[1]), .issue_accept(acc[1]),
    .wb_valid(wbv[1]), .wb_rd(wbr[1]));

  typedef struct {
    int rs0, rs1, iv, wen, rd, lat, hold, flush;
    int hit, sel0, sel1, stall, acc, wbv, wbr;
  } vec_t;

  typedef struct {int z; int rd; int age; int lat;} ent_t;
  ent_t mq[$];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic set_in(input int r0, r1, iv, wen, rd, lat, hd, fl);
    rs_i = {5'(r1), 5'(r0)};
    issue_valid = 1'(iv); issue_wen = 1'(wen); issue_rd = 5'(rd);
    issue_lat = 3'(lat); hold = 1'(hd); flush = 1'(fl);
  endtask

  function automatic vec_t mk(input int r0, r1, iv, wen, rd, lat, hd, fl, h, s0, s1, st, ac, wv, wr);
    vec_t t;
    t.rs0 = r0; t.rs1 = r1; t.iv = iv; t.wen = wen; t.rd = rd; t.lat = lat; t.hold = hd; t.flush = fl;
    t.hit = h; t.sel0 = s0; t.sel1 = s1; t.stall = st; t.acc = ac; t.wbv = wv; t.wbr = wr;
    return t;
  endfunction

  // Youngest in-flight writer of rs (smallest age) for instance z; ready once age reaches lat-1
  function automatic void mlook(input int z, input int rs, output bit f, output bit r, output int s);
    int best = DEPTH;
    f = 0; r = 0; s = 0;
    if (z == 1 && rs == 0) return;
    foreach (mq[i])
      if (mq[i].z == z && mq[i].rd == rs && mq[i].age < best) begin
        best = mq[i].age; f = 1; r = mq[i].age >= mq[i].lat - 1; s = mq[i].age;
      end
  endfunction

  function automatic void mexp(input int z, output int h, output int s0, output int s1,
                               output int st, output int ac, output int wv, output int wr);
    bit f0, r0, f1, r1;
    mlook(z, int'(rs_i[4:0]), f0, r0, s0);
    mlook(z, int'(rs_i[9:5]), f1, r1, s1);
    st = int'((f0 && !r0) || (f1 && !r1));
    h = int'(f0 && r0) + 2 * int'(f1 && r1);
    ac = int'(issue_valid && st == 0 && !hold && !flush);
    wv = 0; wr = 0;
    foreach (mq[i])
      if (mq[i].z == z && mq[i].age == DEPTH - 1) begin
        wv = int'(!hold && !flush); wr = mq[i].rd;
      end
  endfunction

  task automatic mupdate();
    int h, s0, s1, st, wv, wr;
    int ac [2];
    int lc;
    for (int z = 0; z < 2; z++) mexp(z, h, s0, s1, st, ac[z], wv, wr);
    if (flush) mq.delete();
    else if (!hold) begin
      foreach (mq[i]) mq[i].age++;
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].age >= DEPTH) mq.delete(i);
      lc = issue_lat == 0 ? 1 : (int'(issue_lat) > DEPTH ? DEPTH : int'(issue_lat));
      for (int z = 0; z < 2; z++)
        if (ac[z] != 0 && issue_wen && !(z == 1 && issue_rd == 0))
          mq.push_back('{z, int'(issue_rd), 0, lc});
    end
  endtask

  task automatic check_model();
    int h, s0, s1, st, ac, wv, wr;
    for (int z = 0; z < 2; z++) begin
      mexp(z, h, s0, s1, st, ac, wv, wr);
      chk($sformatf("m%0d hit", z), int'(hit[z]), h);
      chk($sformatf("m%0d stall", z), int'(stall[z]), st);
      chk($sformatf("m%0d accept", z), int'(acc[z]), ac);
      chk($sformatf("m%0d wb_valid", z), int'(wbv[z]), wv);
      chk($sformatf("m%0d sel0", z), int'(sel[z][1:0]), s0);
      chk($sformatf("m%0d sel1", z), int'(sel[z][3:2]), s1);
      if (wv != 0) chk($sformatf("m%0d wb_rd", z), int'(wbr[z]), wr);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    mupdate();
    #1;
  endtask

  vec_t tbl [24];

  initial begin
    tbl[0]  = mk(3,5,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tbl[1]  = mk(3,5,1,1,7,1,0,0, 0,0,0,0,1,0,0);
    tbl[2]  = mk(7,5,0,0,0,0,0,0, 1,0,0,0,0,0,0);
    tbl[3]  = mk(7,5,0,0,0,0,0,0, 1,1,0,0,0,0,0);
    tbl[4]  = mk(7,5,0,0,0,0,0,0, 1,2,0,0,0,0,0);
    tbl[5]  = mk(7,5,0,0,0,0,0,0, 1,3,0,0,0,1,7);
    tbl[6]  = mk(7,5,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tbl[7]  = mk(0,4,1,1,4,3,0,0, 0,0,0,0,1,0,0);
    tbl[8]  = mk(0,4,1,1,9,1,0,0, 0,0,0,1,0,0,0);
    tbl[9]  = mk(0,4,1,1,9,1,0,0, 0,0,1,1,0,0,0);
    tbl[10] = mk(0,4,1,1,9,1,0,0, 2,0,2,0,1,0,0);
    tbl[11] = mk(9,4,0,0,0,0,0,0, 3,0,3,0,0,1,4);
    tbl[12] = mk(0,0,1,1,2,1,0,0, 0,0,0,0,1,0,0);
    tbl[13] = mk(9,0,1,1,2,2,0,0, 1,2,0,0,1,0,0);
    tbl[14] = mk(2,0,0,0,0,0,0,0, 0,0,0,1,0,1,9);
    tbl[15] = mk(2,0,0,0,0,0,0,0, 1,1,0,0,0,0,0);
    tbl[16] = mk(0,0,1,1,6,3,0,0, 0,0,0,0,1,1,2);
    tbl[17] = mk(0,6,0,0,0,0,1,0, 0,0,0,1,0,0,0);
    tbl[18] = mk(0,6,0,0,0,0,1,0, 0,0,0,1,0,0,0);
    tbl[19] = mk(0,6,0,0,0,0,1,0, 0,0,0,1,0,0,0);
    tbl[20] = mk(0,6,0,0,0,0,1,1, 0,0,0,1,0,0,0);
    tbl[21] = mk(2,6,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tbl[22] = mk(0,0,1,1,3,1,0,1, 0,0,0,0,0,0,0);
    tbl[23] = mk(3,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

    issue_valid = 1'b1;
    #3;
    for (int z = 0; z < 2; z++) begin
      chk("reset hit", int'(hit[z]), 0);
      chk("reset sel", int'(sel[z]), 0);
      chk("reset stall", int'(stall[z]), 0);
      chk("reset wb_valid", int'(wbv[z]), 0);
      chk("reset wb_rd", int'(wbr[z]), 0);
      chk("reset accept", int'(acc[z]), 1);
    end
    issue_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].rs0, tbl[i].rs1, tbl[i].iv, tbl[i].wen, tbl[i].rd, tbl[i].lat, tbl[i].hold, tbl[i].flush);
      @(negedge clk);
      chk($sformatf("t%0d hit", i), int'(hit[0]), tbl[i].hit);
      chk($sformatf("t%0d sel0", i), int'(sel[0][1:0]), tbl[i].sel0);
      chk($sformatf("t%0d sel1", i), int'(sel[0][3:2]), tbl[i].sel1);
      chk($sformatf("t%0d stall", i), int'(stall[0]), tbl[i].stall);
      chk($sformatf("t%0d accept", i), int'(acc[0]), tbl[i].acc);
      chk($sformatf("t%0d wb_valid", i), int'(wbv[0]), tbl[i].wbv);
      if (tbl[i].wbv != 0) chk($sformatf("t%0d wb_rd", i), int'(wbr[0]), tbl[i].wbr);
      check_model();
      @(posedge clk);
      mupdate();
      #1;
    end

    set_in(0, 0, 1, 1, 0, 1, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zs hit", int'(hit[1]), 0);
      chk("zs stall", int'(stall[1]), 0);
      chk("zs wb_valid", int'(wbv[1]), 0);
      check_model();
      @(posedge clk);
      mupdate();
      #1;
    end

    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 3) != 0),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
             int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 19) == 0));
      cyc();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    set_in(0, 0, 1, 1, 5, 4, 0, 0);
    cyc();
    set_in(5, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk("pre-reset stall", int'(stall[0]), 1);
    #2 rstn = 1'b0;
    #1;
    mq.delete();
    for (int z = 0; z < 2; z++) begin
      chk("async hit", int'(hit[z]), 0);
      chk("async sel", int'(sel[z]), 0);
      chk("async stall", int'(stall[z]), 0);
      chk("async wb_valid", int'(wbv[z]), 0);
      chk("async wb_rd", int'(wbr[z]), 0);
    end
    #1 rstn = 1'b1;
    @(posedge clk);
    mupdate();
    #1;
    for (int i = 0; i < 5; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
